key_encoder83_sync: RTL and testbench

Registered 8-to-3 priority encoder for active-low key/request lines. It is the encoding counterpart to the active-low 2-to-4 and 3-to-8 decoders in the decoder library. It synchronizes and debounces the lines, captures the highest-index asserted line as a 3-bit code, and presents it on a valid/ack handshake. It then waits for all lines to release before arming for the next capture.

---
 rtl/key_enc_pkg.sv | 20 ++
 rtl/sync_ff2.sv | 23 ++
 rtl/key_encoder83_sync.sv | 86 ++++++++
 tb/tb_key_encoder83_sync.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/key_enc_pkg.sv
// key_enc_pkg: shared state type, code width and line-encoding helpers
// for the registered 8-to-3 key encoder.
package key_enc_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, VALID, RELEASE} state_t;

    // Later iterations overwrite earlier ones, so the highest zero wins.
    function automatic logic [CODE_W-1:0] prio_enc(input logic [7:0] v);
        prio_enc = '0;
        for (int i = 0; i < 8; i++)
            if (!v[i]) prio_enc = CODE_W'(i);
    endfunction

    function automatic logic multi_zero(input logic [7:0] v);
        multi_zero = $countones(~v) > 1;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// sync_ff2: two-flop synchronizer, resets to all ones (all lines released).
module sync_ff2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_encoder83_sync.sv
// key_encoder83_sync: debounced, registered 8-to-3 priority encoder for
// active-low key lines with a valid/ack handshake and release re-arming.
module key_encoder83_sync
    import key_enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              e_n,
    input  logic [7:0]        n_key,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              multi,
    output logic              valid
);

    logic [7:0]        ks;
    state_t            state, state_d;
    logic [7:0]        cnt, cnt_d;
    logic [CODE_W-1:0] cap_code, cap_d, code_d, cand;
    logic              multi_d, pressed, done;

    sync_ff2 #(.W(8)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (n_key),
        .q   (ks)
    );

    assign pressed = ~&ks;
    assign cand    = prio_enc(ks);
    assign done    = cnt == 8'(DEBOUNCE_CYCLES - 1);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cap_d   = cap_code;
        code_d  = code;
        multi_d = multi;
        case (state)
            IDLE:
                if (!e_n && pressed) begin
                    state_d = DEBOUNCE;
                    cap_d   = cand;
                    cnt_d   = '0;
                end
            DEBOUNCE:
                if (!pressed || cand != cap_code || e_n) state_d = IDLE;
                else if (done) begin
                    state_d = VALID;
                    code_d  = cap_code;
                    multi_d = multi_zero(ks);
                end else cnt_d = cnt + 8'd1;
            VALID:
                if (ack) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            RELEASE:
                if (pressed) cnt_d = '0;
                else if (done) state_d = IDLE;
                else cnt_d = cnt + 8'd1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_code <= '0;
            code     <= '0;
            multi    <= 1'b0;
            valid    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            cap_code <= cap_d;
            code     <= code_d;
            multi    <= multi_d;
            valid    <= state_d == VALID;
        end
    end

endmodule

// File: tb/tb_key_encoder83_sync.sv
// tb_key_encoder83_sync: directed plan steps plus randomized key traffic,
// checked every cycle against a run-length reference model.
module tb_key_encoder83_sync;

    localparam int D = 4;

    logic       clk = 1'b0, rst = 1'b1, e_n = 1'b0, ack = 1'b0;
    logic [7:0] n_key = 8'hFF;
    logic [2:0] code;
    logic       multi, valid;

    int n_vec = 0, n_bad = 0;

    // Model: two-sample delay line, phase 0 armed / 1 offered / 2 releasing.
    logic [7:0] s1 = '1, s2 = '1;
    int         phase = 0, run = 0, rel = 0;
    logic [2:0] rc = '0, m_code = '0;
    logic       m_multi = 1'b0;

    key_encoder83_sync #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .e_n   (e_n),
        .n_key (n_key),
        .ack   (ack),
        .code  (code),
        .multi (multi),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic int hi_zero(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            if (!v[i]) return i;
        return -1;
    endfunction

    function automatic int zeros(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++)
            if (!v[i]) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed={valid,multi,code}=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            s1 = '1; s2 = '1; phase = 0; run = 0; rel = 0;
            rc = '0; m_code = '0; m_multi = 1'b0;
        end else begin
            case (phase)
                0: begin
                    // a press is accepted after D+1 consecutive qualifying samples of one line
                    if (s2 != 8'hFF && !e_n && (run == 0 || hi_zero(s2) == int'(rc))) begin
                        run++;
                        rc = 3'(hi_zero(s2));
                    end else run = 0;
                    if (run == D + 1) begin
                        phase = 1; m_code = rc; m_multi = zeros(s2) > 1; run = 0;
                    end
                end
                1: if (ack) begin phase = 2; rel = 0; end
                default: begin
                    rel = (s2 == 8'hFF) ? rel + 1 : 0;
                    if (rel == D) phase = 0;
                end
            endcase
            s2 = s1;
            s1 = n_key;
        end
        #1;
        chk("cycle", {valid, multi, code}, {phase == 1, m_multi, m_code});
    endtask

    task automatic do_ack();
        ack = 1'b1; step(); ack = 1'b0;
        chk("ack_drop", {4'b0, valid}, 5'd0);
    endtask

    task automatic do_release();
        n_key = 8'hFF;
        repeat (2 + D) step();
    endtask

    logic [7:0] pats [6] = '{8'hFF, 8'hF7, 8'h5E, 8'hFE, 8'h7F, 8'h00};

    initial begin
        // Reset with all lines pressed
        rst = 1'b1; n_key = 8'h00;
        step(); step();
        chk("reset", {valid, multi, code}, 5'd0);
        rst = 1'b0;
        repeat (6) step();
        chk("post_reset_no_early", {4'b0, valid}, 5'd0);
        step();
        chk("post_reset_capture", {valid, multi, code}, {2'b11, 3'd7});
        do_ack(); do_release();

        // Single key: valid exactly after edge 7
        n_key = 8'hF7;
        repeat (6) step();
        chk("single_edge6", {4'b0, valid}, 5'd0);
        step();
        chk("single_edge7", {valid, multi, code}, {2'b10, 3'd3});
        do_ack(); do_release();

        // Priority and multi
        n_key = 8'h5E;
        repeat (7) step();
        chk("priority", {valid, multi, code}, {2'b11, 3'd7});
        do_ack(); do_release();

        // Bounce
        for (int i = 0; i < 20; i++) begin
            n_key = ((i / 2) % 2) ? 8'hFF : 8'hF7;
            step();
            chk("bounce_quiet", {4'b0, valid}, 5'd0);
        end
        n_key = 8'hF7;
        repeat (10) step();
        chk("bounce_settled", {valid, multi, code}, {2'b10, 3'd3});
        do_ack(); do_release();

        // Enable gating and hold-through
        e_n = 1'b1; n_key = 8'hFE;
        repeat (10) step();
        chk("enable_block", {4'b0, valid}, 5'd0);
        e_n = 1'b0;
        repeat (6) step();
        chk("enable_capture", {valid, multi, code}, {2'b10, 3'd0});
        e_n = 1'b1;
        repeat (5) step();
        chk("valid_persists", {valid, multi, code}, {2'b10, 3'd0});
        e_n = 1'b0;
        do_ack();
        repeat (20) step();
        chk("held_no_second", {4'b0, valid}, 5'd0);
        do_release();

        // Ack while idle is ignored, then reset mid-VALID
        ack = 1'b1; repeat (3) step(); ack = 1'b0;
        n_key = 8'hDF;
        repeat (7) step();
        chk("pre_reset_valid", {valid, multi, code}, {2'b10, 3'd5});
        rst = 1'b1; step(); rst = 1'b0;
        chk("reset_mid_valid", {valid, multi, code}, 5'd0);

        // Randomized traffic
        for (int s = 0; s < 300; s++) begin
            n_key = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pats[$urandom_range(0, 5)];
            repeat ($urandom_range(1, 12)) begin
                e_n = $urandom_range(0, 9) == 0;
                ack = $urandom_range(0, 3) == 0;
                rst = $urandom_range(0, 199) == 0;
                step();
            end
        end
        rst = 1'b0; ack = 1'b0; e_n = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
